nova_io_bus: RTL and testbench

NOVA_IO_BUS -- requirements
Module: nova_io_bus

---
 rtl/nova_io_bus_pkg.sv | 56 +++++
 rtl/nova_io_bus_tmo.sv | 29 ++
 rtl/nova_io_bus.sv | 203 ++++++++++++++++++++
 tb/tb_nova_io_bus.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nova_io_bus_pkg.sv
// rtl/nova_io_bus_pkg.sv - shared codes, field positions and state encodings for nova_io_bus
package nova_io_bus_pkg;

    // Transfer field of an I/O instruction
    typedef enum logic [2:0] {
        XF_NIO = 3'b000,
        XF_DIA = 3'b001,
        XF_DOA = 3'b010,
        XF_DIB = 3'b011,
        XF_DOB = 3'b100,
        XF_DIC = 3'b101,
        XF_DOC = 3'b110,
        XF_SKP = 3'b111
    } xfer_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_CTRL = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Instruction bit k (bit 0 = MSB) lives at vector index 15-k
    localparam int INST_TAG_HI  = 15;
    localparam int INST_TAG_LO  = 13;
    localparam int INST_XFER_HI = 10;
    localparam int INST_XFER_LO = 8;
    localparam int INST_CTRL_HI = 7;
    localparam int INST_CTRL_LO = 6;
    localparam int INST_DEV_LO  = 0;

    localparam logic [2:0] IO_TAG = 3'b011;

    localparam logic [1:0] REG_STAT = 2'b00;
    localparam logic [1:0] REG_A    = 2'b01;
    localparam logic [1:0] REG_B    = 2'b10;
    localparam logic [1:0] REG_C    = 2'b11;

    function automatic logic [1:0] reg_sel(input xfer_e x);
        case (x)
            XF_DIA, XF_DOA: reg_sel = REG_A;
            XF_DIB, XF_DOB: reg_sel = REG_B;
            XF_DIC, XF_DOC: reg_sel = REG_C;
            default:        reg_sel = REG_STAT;
        endcase
    endfunction

    function automatic logic is_in(input xfer_e x);
        is_in = (x == XF_DIA) || (x == XF_DIB) || (x == XF_DIC);
    endfunction

    function automatic logic is_out(input xfer_e x);
        is_out = (x == XF_DOA) || (x == XF_DOB) || (x == XF_DOC);
    endfunction

endpackage

// File: rtl/nova_io_bus_tmo.sv
// rtl/nova_io_bus_tmo.sv - strobe-cycle counter flagging a bus cycle that never acknowledged
module nova_io_bus_tmo #(
    parameter int TMO = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    output logic o_hit
);

    localparam logic [15:0] LIMIT = 16'(TMO - 1);

    logic [15:0] r_cnt;

    // Count strobe-high cycles; any low-strobe cycle restarts the count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_run) begin
            r_cnt <= '0;
        end else if (r_cnt != LIMIT) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Fires in the TMO-th strobe cycle; an ack in that same cycle still wins in the FSM
    assign o_hit = i_run && (r_cnt == LIMIT);

endmodule

// File: rtl/nova_io_bus.sv
// rtl/nova_io_bus.sv - Nova-style I/O instruction to bus-cycle sequencer (optional NOVA_IO_BUS_TIMEOUT_EN)
module nova_io_bus
    import nova_io_bus_pkg::*;
#(
    parameter int DW   = 16,
    parameter int DEVW = 6,
    parameter int TMO  = 255
) (
    input  logic            pclk,
    input  logic            prst_n,
    input  logic [15:0]     io_inst,
    input  logic [DW-1:0]   io_op,
    input  logic            io_pulse,
    output logic [DW-1:0]   io_result,
    output logic            io_skip,
    output logic            io_err,
    output logic            io_busy,
    output logic            bs_stb,
    output logic            bs_we,
    output logic [DEVW+1:0] bs_adr,
    output logic [DW-1:0]   bs_dout,
    input  logic [DW-1:0]   bs_din,
    input  logic            bs_ack
);

    if (DW < 16 || DW > 32 || DEVW < 1 || DEVW > 6 || TMO < 1 || TMO > 65535) begin : g_bad_param
        $error("nova_io_bus: parameter out of range");
    end

    state_e          r_state, w_state_nxt;
    xfer_e           r_xfer, w_xfer_nxt;
    logic [1:0]      r_ctrl, w_ctrl_nxt;
    logic            r_stb, w_stb_nxt;
    logic            r_we, w_we_nxt;
    logic [DEVW+1:0] r_adr, w_adr_nxt;
    logic [DW-1:0]   r_dout, w_dout_nxt;
    logic [DW-1:0]   r_result, w_result_nxt;
    logic            r_skip, w_skip_nxt;
    logic            r_err, w_err_nxt;

    logic            w_accept;
    logic            w_ack;
    logic            w_tmo_hit;
    xfer_e           w_xfer_in;
    logic [1:0]      w_ctrl_in;
    logic [DEVW-1:0] w_dev;
    logic            w_unused;

    assign w_xfer_in = xfer_e'(io_inst[INST_XFER_HI:INST_XFER_LO]);
    assign w_ctrl_in = io_inst[INST_CTRL_HI:INST_CTRL_LO];
    assign w_dev     = io_inst[INST_DEV_LO +: DEVW];
    assign w_accept  = (r_state == ST_IDLE) && io_pulse
                       && (io_inst[INST_TAG_HI:INST_TAG_LO] == IO_TAG);
    // An ack only counts while a strobe is actually out
    assign w_ack     = r_stb && bs_ack;

`ifdef NOVA_IO_BUS_TIMEOUT_EN
    nova_io_bus_tmo #(
        .TMO(TMO)
    ) u_tmo (
        .i_clk  (pclk),
        .i_rst_n(prst_n),
        .i_run  (r_stb),
        .o_hit  (w_tmo_hit)
    );
    assign io_err   = r_err;
    assign w_unused = ^io_inst[12:11];
`else
    assign w_tmo_hit = 1'b0;
    assign io_err    = 1'b0;
    assign w_unused  = ^{io_inst[12:11], r_err};
`endif

    // Next-state and next register values; the bus outputs are registered so they stay glitch-free
    always_comb begin
        w_state_nxt  = r_state;
        w_xfer_nxt   = r_xfer;
        w_ctrl_nxt   = r_ctrl;
        w_stb_nxt    = r_stb;
        w_we_nxt     = r_we;
        w_adr_nxt    = r_adr;
        w_dout_nxt   = r_dout;
        w_result_nxt = r_result;
        w_skip_nxt   = r_skip;
        w_err_nxt    = r_err;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_xfer_nxt = w_xfer_in;
                    w_ctrl_nxt = w_ctrl_in;
                    w_skip_nxt = 1'b0;
                    w_err_nxt  = 1'b0;
                    if (w_xfer_in == XF_NIO) begin
                        if (w_ctrl_in == 2'b00) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_CTRL;
                            w_stb_nxt   = 1'b1;
                            w_we_nxt    = 1'b1;
                            w_adr_nxt   = {w_dev, REG_STAT};
                            w_dout_nxt  = {{(DW-2){1'b0}}, w_ctrl_in};
                        end
                    end else begin
                        w_state_nxt = ST_XFER;
                        w_stb_nxt   = 1'b1;
                        w_we_nxt    = is_out(w_xfer_in);
                        w_adr_nxt   = {w_dev, reg_sel(w_xfer_in)};
                        w_dout_nxt  = is_out(w_xfer_in) ? io_op : '0;
                    end
                end
            end
            ST_XFER: begin
                if (w_ack) begin
                    w_stb_nxt = 1'b0;
                    w_we_nxt  = 1'b0;
                    if (is_in(r_xfer)) begin
                        w_result_nxt = bs_din;
                    end
                    if (r_xfer == XF_SKP) begin
                        w_skip_nxt = (r_ctrl[1] ? bs_din[1] : bs_din[0]) ^ r_ctrl[0];
                    end
                    if ((r_ctrl != 2'b00) && (r_xfer != XF_SKP)) begin
                        // Set up the control write now; the strobe rises one cycle later
                        w_state_nxt = ST_CTRL;
                        w_we_nxt    = 1'b1;
                        w_adr_nxt   = {r_adr[DEVW+1:2], REG_STAT};
                        w_dout_nxt  = {{(DW-2){1'b0}}, r_ctrl};
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else if (w_tmo_hit) begin
                    w_stb_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_CTRL: begin
                if (!r_stb) begin
                    w_stb_nxt = 1'b1;
                end else if (w_ack) begin
                    w_stb_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_state_nxt = ST_DONE;
                end else if (w_tmo_hit) begin
                    w_stb_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latched instruction fields, bus outputs and results; reset clears everything mid-transfer
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_xfer   <= XF_NIO;
            r_ctrl   <= 2'b00;
            r_stb    <= 1'b0;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_dout   <= '0;
            r_result <= '0;
            r_skip   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_xfer   <= w_xfer_nxt;
            r_ctrl   <= w_ctrl_nxt;
            r_stb    <= w_stb_nxt;
            r_we     <= w_we_nxt;
            r_adr    <= w_adr_nxt;
            r_dout   <= w_dout_nxt;
            r_result <= w_result_nxt;
            r_skip   <= w_skip_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign io_result = r_result;
    assign io_skip   = r_skip;
    assign io_busy   = prst_n && ((r_state != ST_IDLE) || io_pulse);
    assign bs_stb    = r_stb;
    assign bs_we     = r_we;
    assign bs_adr    = r_adr;
    assign bs_dout   = r_dout;

endmodule

// File: tb/tb_nova_io_bus.sv
// tb/tb_nova_io_bus.sv - self-checking bench for nova_io_bus
module tb_nova_io_bus;

    localparam int DW   = 16;
    localparam int DEVW = 6;
    localparam int TMO  = 4;

    logic          pclk = 1'b0;
    logic          prst_n;
    logic [15:0]   io_inst;
    logic [DW-1:0] io_op;
    logic          io_pulse;
    logic [DW-1:0] io_result;
    logic          io_skip;
    logic          io_err;
    logic          io_busy;
    logic          bs_stb;
    logic          bs_we;
    logic [7:0]    bs_adr;
    logic [DW-1:0] bs_dout;
    logic [DW-1:0] bs_din;
    logic          bs_ack;

    nova_io_bus #(.DW(DW), .DEVW(DEVW), .TMO(TMO)) dut (
        .pclk(pclk), .prst_n(prst_n), .io_inst(io_inst), .io_op(io_op), .io_pulse(io_pulse),
        .io_result(io_result), .io_skip(io_skip), .io_err(io_err), .io_busy(io_busy),
        .bs_stb(bs_stb), .bs_we(bs_we), .bs_adr(bs_adr), .bs_dout(bs_dout),
        .bs_din(bs_din), .bs_ack(bs_ack)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [7:0]  adr;
        logic        we;
        logic [15:0] dout;
    } bus_t;

    typedef struct {
        logic [15:0] inst;
        logic [15:0] op;
        logic [15:0] din;
        int          delay;
        logic [15:0] exp_result;
        logic        exp_skip;
        int          exp_lat;
        int          exp_stb;
    } vec_t;

    bus_t sb_q[$];
    vec_t vecs[14];

    int n_checks = 0;
    int n_fail   = 0;
    int g_delay  = 1;
    bit g_force_ack = 1'b0;
    int g_stb_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int xfer, input int ctrl, input int dev);
        return {3'b011, 2'b00, xfer[2:0], ctrl[1:0], dev[5:0]};
    endfunction

    // Expected bus cycles for one instruction, derived from the instruction encoding
    task automatic push_expected(input logic [15:0] inst, input logic [15:0] op);
        logic [2:0] x;
        logic [1:0] c;
        logic [1:0] rs;
        bus_t e;
        x = inst[10:8];
        c = inst[7:6];
        if (x != 3'd0) begin
            case (x)
                3'd1, 3'd2: rs = 2'b01;
                3'd3, 3'd4: rs = 2'b10;
                3'd5, 3'd6: rs = 2'b11;
                default:    rs = 2'b00;
            endcase
            e.we   = (x == 3'd2) || (x == 3'd4) || (x == 3'd6);
            e.adr  = {inst[5:0], rs};
            e.dout = e.we ? op : 16'h0000;
            sb_q.push_back(e);
        end
        if (c != 2'b00 && x != 3'd7) begin
            e.adr  = {inst[5:0], 2'b00};
            e.we   = 1'b1;
            e.dout = {14'd0, c};
            sb_q.push_back(e);
        end
    endtask

    // Bus responder: acks the g_delay-th strobe cycle and checks each completed cycle against the scoreboard
    initial begin : responder
        int cnt;
        bus_t first;
        bus_t e;
        cnt = 0;
        bs_ack = 1'b0;
        forever begin
            @(negedge pclk);
            if (bs_stb) begin
                cnt++;
                g_stb_cycles++;
                if (cnt == 1) begin
                    first.adr = bs_adr; first.we = bs_we; first.dout = bs_dout;
                end
                if (g_delay != 0 && cnt == g_delay) begin
                    bs_ack = 1'b1;
                    check("bus_stable", {7'd0, bs_adr, bs_we, bs_dout}, {7'd0, first.adr, first.we, first.dout});
                    if (sb_q.size() == 0) begin
                        check("sb_extra_cycle", {8'd0, bs_adr, bs_we, 15'd0}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb_q.pop_front();
                        check("bus_adr", {24'd0, bs_adr}, {24'd0, e.adr});
                        check("bus_we", {31'd0, bs_we}, {31'd0, e.we});
                        if (e.we) check("bus_dout", {16'd0, bs_dout}, {16'd0, e.dout});
                    end
                end else begin
                    bs_ack = g_force_ack;
                end
            end else begin
                cnt = 0;
                bs_ack = g_force_ack;
            end
        end
    end

    task automatic wait_idle(output int lat);
        lat = 1;
        while (io_busy && lat < 200) begin
            lat++;
            @(negedge pclk);
            #1;
        end
    endtask

    task automatic run_vec(input logic [15:0] inst, input logic [15:0] op, input logic [15:0] din,
                           input int delay, output int lat);
        @(negedge pclk);
        bs_din = din; g_delay = delay; io_inst = inst; io_op = op; io_pulse = 1'b1;
        g_stb_cycles = 0;
        @(negedge pclk);
        io_pulse = 1'b0; io_inst = 16'h0000; io_op = ~op;
        #1;
        wait_idle(lat);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        int lat;
        prst_n = 1'b0; io_pulse = 1'b0; io_inst = 16'h0; io_op = '0; bs_din = '0;
        repeat (3) @(negedge pclk);
        io_pulse = 1'b1;
        #1;
        check("rst_busy", {31'd0, io_busy}, 32'd0);
        check("rst_stb", {31'd0, bs_stb}, 32'd0);
        check("rst_result", {16'd0, io_result}, 32'd0);
        check("rst_flags", {29'd0, io_skip, io_err, bs_we}, 32'd0);
        check("rst_adr_dout", {8'd0, bs_adr, bs_dout}, 32'd0);
        @(negedge pclk);
        io_pulse = 1'b0;
        prst_n = 1'b1;

        vecs[0]  = '{mk(1, 0, 8'o12), 16'h0000, 16'hBEEF, 2, 16'hBEEF, 1'b0, 4, 2};
        vecs[1]  = '{mk(4, 1, 8'o03), 16'h1234, 16'h0000, 1, 16'hBEEF, 1'b0, 5, 2};
        vecs[2]  = '{mk(7, 3, 8'o01), 16'h0000, 16'h0000, 1, 16'hBEEF, 1'b1, 3, 1};
        vecs[3]  = '{mk(7, 3, 8'o01), 16'h0000, 16'h0002, 1, 16'hBEEF, 1'b0, 3, 1};
        vecs[4]  = '{mk(7, 0, 8'o02), 16'h0000, 16'h0001, 1, 16'hBEEF, 1'b1, 3, 1};
        vecs[5]  = '{mk(7, 1, 8'o02), 16'h0000, 16'h0001, 1, 16'hBEEF, 1'b0, 3, 1};
        vecs[6]  = '{mk(7, 2, 8'o02), 16'h0000, 16'h0002, 2, 16'hBEEF, 1'b1, 4, 2};
        vecs[7]  = '{mk(5, 2, 8'o77), 16'h0000, 16'h5A5A, 3, 16'h5A5A, 1'b0, 9, 6};
        vecs[8]  = '{mk(6, 0, 8'o01), 16'hA5A5, 16'h0000, 1, 16'h5A5A, 1'b0, 3, 1};
        vecs[9]  = '{mk(0, 0, 8'o11), 16'h0000, 16'h0000, 1, 16'h5A5A, 1'b0, 2, 0};
        vecs[10] = '{mk(0, 3, 8'o05), 16'h0000, 16'h0000, 1, 16'h5A5A, 1'b0, 3, 1};
        vecs[11] = '{mk(3, 0, 8'o40), 16'h0000, 16'h8001, 1, 16'h8001, 1'b0, 3, 1};
        vecs[12] = '{mk(2, 0, 8'o12), 16'hFFFF, 16'h0000, 2, 16'h8001, 1'b0, 4, 2};
        vecs[13] = '{mk(1, 1, 8'o02), 16'h0000, 16'h0000, 1, 16'h0000, 1'b0, 5, 2};

        for (int i = 0; i < 14; i++) begin
            push_expected(vecs[i].inst, vecs[i].op);
            run_vec(vecs[i].inst, vecs[i].op, vecs[i].din, vecs[i].delay, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_stb_cycles", i), g_stb_cycles, vecs[i].exp_stb);
            check($sformatf("v%0d_result", i), {16'd0, io_result}, {16'd0, vecs[i].exp_result});
            check($sformatf("v%0d_skip", i), {31'd0, io_skip}, {31'd0, vecs[i].exp_skip});
            check($sformatf("v%0d_err", i), {31'd0, io_err}, 32'd0);
            check($sformatf("v%0d_sb_missing", i), sb_q.size(), 0);
            sb_q.delete();
        end

        // Ack while no strobe is out is ignored
        @(negedge pclk);
        g_force_ack = 1'b1;
        repeat (3) @(negedge pclk);
        #1;
        check("stray_ack_stb", {31'd0, bs_stb}, 32'd0);
        check("stray_ack_busy", {31'd0, io_busy}, 32'd0);
        g_force_ack = 1'b0;

        // Pulses with a non-I/O tag never start a bus cycle
        g_stb_cycles = 0;
        for (int t = 0; t < 8; t++) begin
            logic [2:0] tag;
            tag = t[2:0];
            if (tag != 3'b011) begin
                @(negedge pclk);
                io_inst = {tag, 2'b00, 3'd1, 2'd0, 6'd1}; io_pulse = 1'b1;
                @(negedge pclk);
                io_pulse = 1'b0;
                repeat (2) @(negedge pclk);
            end
        end
        #1;
        check("bad_tag_stb_cycles", g_stb_cycles, 0);
        check("bad_tag_busy", {31'd0, io_busy}, 32'd0);
        check("bad_tag_result", {16'd0, io_result}, 32'd0);

        // Pulses while busy (XFER and DONE) are ignored
        push_expected(mk(1, 0, 3), 16'h0000);
        @(negedge pclk);
        bs_din = 16'h1111; g_delay = 3; io_inst = mk(1, 0, 3); io_pulse = 1'b1; g_stb_cycles = 0;
        @(negedge pclk);
        io_inst = mk(2, 0, 4); io_op = 16'hDEAD;
        repeat (3) @(negedge pclk);
        io_pulse = 1'b0;
        #1;
        wait_idle(lat);
        repeat (3) @(negedge pclk);
        check("busy_pulse_stb_cycles", g_stb_cycles, 3);
        check("busy_pulse_sb", sb_q.size(), 0);
        check("busy_pulse_result", {16'd0, io_result}, 32'h1111);
        sb_q.delete();

`ifdef NOVA_IO_BUS_TIMEOUT_EN
        // No ack: strobe drops after TMO cycles, control write skipped, result kept
        run_vec(mk(1, 1, 4), 16'h0000, 16'h7777, 0, lat);
        check("tmo_latency", lat, 6);
        check("tmo_stb_cycles", g_stb_cycles, TMO);
        check("tmo_err", {31'd0, io_err}, 32'd1);
        check("tmo_result", {16'd0, io_result}, 32'h1111);
        run_vec(mk(0, 0, 4), 16'h0000, 16'h0000, 1, lat);
        check("tmo_err_cleared", {31'd0, io_err}, 32'd0);
        check("tmo_clear_latency", lat, 2);
`else
        // Without the timeout the block waits out a long ack
        push_expected(mk(1, 0, 4), 16'h0000);
        run_vec(mk(1, 0, 4), 16'h0000, 16'h7777, 6, lat);
        check("long_ack_latency", lat, 8);
        check("long_ack_err", {31'd0, io_err}, 32'd0);
        check("long_ack_result", {16'd0, io_result}, 32'h7777);
        check("long_ack_sb", sb_q.size(), 0);
        sb_q.delete();
`endif

        // Reset in the middle of an unacknowledged bus cycle
        @(negedge pclk);
        g_delay = 0; io_inst = mk(3, 0, 7); io_pulse = 1'b1;
        @(negedge pclk);
        io_pulse = 1'b0;
        @(negedge pclk);
        #2;
        prst_n = 1'b0;
        #1;
        check("midrst_stb", {31'd0, bs_stb}, 32'd0);
        check("midrst_busy", {31'd0, io_busy}, 32'd0);
        check("midrst_result", {16'd0, io_result}, 32'd0);
        check("midrst_adr", {24'd0, bs_adr}, 32'd0);

        // First edge after release accepts a pulse
        @(negedge pclk);
        push_expected(mk(2, 0, 9), 16'h00AA);
        g_delay = 1; io_inst = mk(2, 0, 9); io_op = 16'h00AA; io_pulse = 1'b1;
        prst_n = 1'b1;
        @(negedge pclk);
        io_pulse = 1'b0; io_op = 16'h0000;
        #1;
        check("post_rst_accept", {31'd0, bs_stb}, 32'd1);
        wait_idle(lat);
        check("post_rst_latency", lat, 3);
        check("post_rst_sb", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
